// File: rtl/microwave_timer_ctrl.sv
// Microwave oven controller: door-safe CLOSED/OPEN/COOK/PAUSE/BELL state machine
// with a cook-time countdown, PWM heat power and a bounded-length bell.
// Ports:
//   clk, nrst   clock and synchronous active-low reset
//   door        1 = door open
//   start       request cooking (level)
//   cancel      abort cooking / clear the cook time
//   load        capture load_time into remaining
//   load_time   cook time in whole seconds
//   power       heat on for `power` out of every 2**PWR_W cycles
//   heat        magnetron enable (registered)
//   light       cavity lamp (registered)
//   bell        buzzer (registered)
//   remaining   seconds left (registered)
module microwave_timer_ctrl #(
  parameter int unsigned TIME_W      = 8,
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned PWR_W       = 2,
  parameter int unsigned BELL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              door,
  input  logic              start,
  input  logic              cancel,
  input  logic              load,
  input  logic [TIME_W-1:0] load_time,
  input  logic [PWR_W-1:0]  power,
  output logic              heat,
  output logic              light,
  output logic              bell,
  output logic [TIME_W-1:0] remaining
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BCNT_W  = $clog2(BELL_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_CLOSED,
    ST_OPEN,
    ST_COOK,
    ST_PAUSE,
    ST_BELL
  } state_t;

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   rem_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PWR_W-1:0]    slot_q, slot_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                heat_d, light_d, bell_d;
  logic                tick_c;

  // One-second tick, only while actually cooking
  assign tick_c = (state_q == ST_COOK) && (presc_q == PRESC_W'(TICK_DIV - 1));

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= ST_CLOSED;
      remaining <= '0;
      presc_q   <= '0;
      slot_q    <= '0;
      bcnt_q    <= '0;
      heat      <= 1'b0;
      light     <= 1'b0;
      bell      <= 1'b0;
    end else begin
      state_q   <= state_d;
      remaining <= rem_d;
      presc_q   <= presc_d;
      slot_q    <= slot_d;
      bcnt_q    <= bcnt_d;
      heat      <= heat_d;
      light     <= light_d;
      bell      <= bell_d;
    end
  end

  // Next-state, counter updates and next output values
  always_comb begin
    state_d = state_q;
    rem_d   = remaining;
    presc_d = presc_q;
    slot_d  = slot_q;
    bcnt_d  = bcnt_q;

    unique case (state_q)
      ST_CLOSED: begin
        if (door) begin
          state_d = ST_OPEN;
        end else if (cancel) begin
          rem_d = '0;
        end else if (load) begin
          rem_d = load_time;
        end else if (start && (remaining != '0)) begin
          state_d = ST_COOK;
          presc_d = '0;
          slot_d  = '0;
        end
      end
      ST_OPEN: begin
        if (!door) begin
          state_d = ST_CLOSED;
        end else if (load) begin
          rem_d = load_time;
        end else if (cancel) begin
          rem_d = '0;
        end
      end
      ST_COOK: begin
        // Door wins over a coincident tick; counters do not advance on that edge
        if (door) begin
          state_d = ST_PAUSE;
        end else if (cancel) begin
          state_d = ST_CLOSED;
          rem_d   = '0;
        end else begin
          presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
          slot_d  = slot_q + PWR_W'(1);
          if (tick_c) begin
            if (remaining <= TIME_W'(1)) begin
              rem_d   = '0;
              state_d = ST_BELL;
              bcnt_d  = '0;
            end else begin
              rem_d = remaining - TIME_W'(1);
            end
          end
        end
      end
      ST_PAUSE: begin
        // Resume keeps prescaler and slot where they froze
        if (!door) begin
          state_d = ST_COOK;
        end else if (cancel) begin
          state_d = ST_OPEN;
          rem_d   = '0;
        end
      end
      ST_BELL: begin
        if (door) begin
          state_d = ST_OPEN;
        end else if (cancel) begin
          state_d = ST_CLOSED;
        end else if (bcnt_q < BCNT_W'(BELL_CYCLES)) begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_CLOSED;
      end
    endcase

    light_d = (state_d == ST_OPEN) || (state_d == ST_COOK) || (state_d == ST_PAUSE);
    heat_d  = (state_d == ST_COOK) && (slot_d < power);
    bell_d  = (state_d == ST_BELL) && (bcnt_d < BCNT_W'(BELL_CYCLES));
  end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
module tb_microwave_timer_ctrl;

  logic       clk = 1'b0;
  logic       nrst, door, start, cancel, load;
  logic [7:0] load_time;
  logic [1:0] power;
  logic       heat, light, bell;
  logic [7:0] remaining;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       nrst, door, start, cancel, load;
    logic [7:0] lt;
    logic [1:0] pw;
    logic       heat, light, bell;
    logic [7:0] rem;
  } vec_t;

  vec_t vq[$];

  microwave_timer_ctrl #(
    .TIME_W(8), .TICK_DIV(4), .PWR_W(2), .BELL_CYCLES(3)
  ) dut (
    .clk(clk), .nrst(nrst), .door(door), .start(start), .cancel(cancel),
    .load(load), .load_time(load_time), .power(power),
    .heat(heat), .light(light), .bell(bell), .remaining(remaining)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, d, s, c, l, input logic [7:0] lt,
                             input logic [1:0] pw, input logic h, li, b,
                             input logic [7:0] rem);
    vec_t x;
    x.nrst = r; x.door = d; x.start = s; x.cancel = c; x.load = l;
    x.lt = lt; x.pw = pw; x.heat = h; x.light = li; x.bell = b; x.rem = rem;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic h, li, b, input logic [7:0] rem);
    chk({tag, " heat"}, 32'(heat), 32'(h));
    chk({tag, " light"}, 32'(light), 32'(li));
    chk({tag, " bell"}, 32'(bell), 32'(b));
    chk({tag, " remaining"}, 32'(remaining), 32'(rem));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    nrst = 1'b1; door = 1'b0; start = 1'b0; cancel = 1'b0; load = 1'b0;
    load_time = 8'd0;
  endtask

  task automatic do_reset();
    idle_in();
    nrst = 1'b0;
    cyc();
    nrst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  found;
    bit  heat_seen;

    idle_in();
    nrst  = 1'b0;
    power = 2'd0;

    // nrst door start cancel load lt pw | heat light bell rem
    vq.push_back(v(0,0,0,0,0, 0,3, 0,0,0,0));   // reset
    vq.push_back(v(1,0,0,0,1, 3,3, 0,0,0,3));   // load 3
    vq.push_back(v(1,0,1,0,0, 0,3, 1,1,0,3));   // COOK entry, slot 0
    vq.push_back(v(1,0,0,0,1,99,3, 1,1,0,3));   // load ignored in COOK
    vq.push_back(v(1,0,0,0,0, 0,3, 1,1,0,3));
    vq.push_back(v(1,0,0,0,0, 0,3, 0,1,0,3));   // slot 3 -> heat off
    vq.push_back(v(1,0,0,0,0, 0,3, 1,1,0,2));   // first tick
    vq.push_back(v(1,0,0,0,0, 0,3, 1,1,0,2));
    vq.push_back(v(1,0,0,0,0, 0,3, 1,1,0,2));
    vq.push_back(v(1,0,0,0,0, 0,3, 0,1,0,2));
    vq.push_back(v(1,0,0,0,0, 0,3, 1,1,0,1));
    vq.push_back(v(1,0,0,0,0, 0,3, 1,1,0,1));
    vq.push_back(v(1,0,0,0,0, 0,3, 1,1,0,1));
    vq.push_back(v(1,0,0,0,0, 0,3, 0,1,0,1));
    vq.push_back(v(1,0,0,0,0, 0,3, 0,0,1,0));   // BELL 12 edges after entry
    vq.push_back(v(1,0,1,0,0, 0,3, 0,0,1,0));   // start ignored in BELL
    vq.push_back(v(1,0,0,0,0, 0,3, 0,0,1,0));
    vq.push_back(v(1,0,0,0,0, 0,3, 0,0,0,0));   // bell silent after 3 cycles
    vq.push_back(v(1,0,0,0,0, 0,3, 0,0,0,0));
    vq.push_back(v(1,0,0,1,0, 0,3, 0,0,0,0));   // cancel -> CLOSED
    vq.push_back(v(1,0,1,0,0, 0,3, 0,0,0,0));   // start blocked, remaining 0
    vq.push_back(v(1,1,1,0,0, 0,3, 0,1,0,0));   // door+start -> OPEN
    vq.push_back(v(1,1,0,0,1, 7,3, 0,1,0,7));   // load with door open
    vq.push_back(v(1,0,0,0,0, 0,3, 0,0,0,7));   // door closed -> CLOSED
    vq.push_back(v(1,0,1,0,1, 5,3, 0,0,0,5));   // load wins over start
    vq.push_back(v(1,0,1,0,0, 0,2, 1,1,0,5));   // COOK, power 2
    vq.push_back(v(1,0,0,0,0, 0,2, 1,1,0,5));   // slot 1 < 2
    vq.push_back(v(1,0,0,0,0, 0,2, 0,1,0,5));   // slot 2 -> off
    vq.push_back(v(1,0,0,1,0, 0,2, 0,0,0,0));   // cancel at remaining 5
    vq.push_back(v(1,0,1,0,0, 0,2, 0,0,0,0));   // start blocked again

    foreach (vq[i]) begin
      nrst = vq[i].nrst; door = vq[i].door; start = vq[i].start;
      cancel = vq[i].cancel; load = vq[i].load;
      load_time = vq[i].lt; power = vq[i].pw;
      cyc();
      chk_out($sformatf("vec%0d", i), vq[i].heat, vq[i].light, vq[i].bell, vq[i].rem);
    end

    // Pause at remaining 2, resume; BELL still needs 8 more counting edges
    do_reset();
    load = 1'b1; load_time = 8'd3; power = 2'd3;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    chk("pause pre remaining", 32'(remaining), 32'd2);
    door = 1'b1;
    cyc();
    chk_out("pause entry", 1'b0, 1'b1, 1'b0, 8'd2);
    cyc(); cyc();
    chk_out("pause held", 1'b0, 1'b1, 1'b0, 8'd2);
    door = 1'b0;
    cyc();
    chk_out("resume", 1'b1, 1'b1, 1'b0, 8'd2);
    found = 1'b0; n = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      cyc();
      if (bell) begin found = 1'b1; n = i; end
    end
    chk("pause bell latency", 32'(n), 32'd8);

    // Cancel in PAUSE -> OPEN with remaining cleared
    do_reset();
    load = 1'b1; load_time = 8'd4; power = 2'd1;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0; door = 1'b1;
    cyc();
    chk_out("pause2", 1'b0, 1'b1, 1'b0, 8'd4);
    cancel = 1'b1;
    cyc();
    chk_out("cancel pause", 1'b0, 1'b1, 1'b0, 8'd0);
    cancel = 1'b0; door = 1'b0;
    cyc();
    chk_out("open to closed", 1'b0, 1'b0, 1'b0, 8'd0);

    // Reset behaviour: pulse between edges is ignored, reset at an edge aborts
    do_reset();
    load = 1'b1; load_time = 8'd9; power = 2'd1;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    chk_out("rst cook entry", 1'b1, 1'b1, 1'b0, 8'd9);
    start = 1'b0;
    cyc();
    chk_out("rst cook slot1", 1'b0, 1'b1, 1'b0, 8'd9);
    #2 nrst = 1'b0;
    #2 nrst = 1'b1;
    cyc();
    chk_out("glitch ignored", 1'b0, 1'b1, 1'b0, 8'd9);
    nrst = 1'b0;
    cyc();
    chk_out("reset mid cook", 1'b0, 1'b0, 1'b0, 8'd0);
    nrst = 1'b1; start = 1'b1;
    cyc();
    chk_out("after reset start", 1'b0, 1'b0, 1'b0, 8'd0);
    start = 1'b0;

    // power 0: no heat, BELL after 8 edges, door in bell cycle 2
    do_reset();
    load = 1'b1; load_time = 8'd2; power = 2'd0;
    cyc();
    load = 1'b0; start = 1'b1;
    cyc();
    chk_out("pw0 entry", 1'b0, 1'b1, 1'b0, 8'd2);
    start = 1'b0;
    heat_seen = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      if (heat) heat_seen = 1'b1;
    end
    chk("pw0 heat seen", 32'(heat_seen), 32'd0);
    chk_out("pw0 before bell", 1'b0, 1'b1, 1'b0, 8'd1);
    cyc();
    chk_out("pw0 bell", 1'b0, 1'b0, 1'b1, 8'd0);
    cyc();
    chk_out("pw0 bell cycle2", 1'b0, 1'b0, 1'b1, 8'd0);
    door = 1'b1;
    cyc();
    chk_out("bell door open", 1'b0, 1'b1, 1'b0, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
